hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Parametrised hazard/stall controller for the 5-stage pipeline. It detects load-use and (optionally) non-forwarded RAW hazards, inserts a configurable number of bubbles, and squashes a configurable number of wrong-path instructions on a taken branch or jump. It also holds a pending redirect across memory-wait stalls and keeps saturating stall and flush statistics. It sits beside the datapath and drives the enable/flush controls of the PC and of every pipeline latch.

## Interface
- REG_W, 5: register index width (matches regbits_t).
- LOAD_LATENCY, 1: bubbles inserted per load-use hazard; legal range 1..7.
- FLUSH_DEPTH, 3: number of younger pipeline latches squashed on redirect; legal range 1..4.
- FORWARD_EN, 1: 1 means only load-use stalls; 0 means stall on any RAW against the EX or MEM destination.
- CNT_W, 16: width of the statistics counters.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- fd_rs1, fd_rs2  in  REG_W  source registers of the instruction in IF/ID.
- fd_rs1_used, fd_rs2_used  in  1  qualifies each source.
- ex_valid, ex_memRead, ex_regWrite  in  1  ID/EX instruction valid, is a load, writes rd.
- ex_rd  in  REG_W  ID/EX destination.
- mem_regWrite  in  1  EX/MEM writes rd.
- mem_rd  in  REG_W  EX/MEM destination.
- branch_taken, jump  in  1  redirect resolved in EX; ignored unless ex_valid=1.
- ihit, dhit, dmem_req  in  1  cache handshake.
- perf_clr  in  1  synchronous clear of the statistics counters.
- stall_all  out  1  freezes every latch and the PC.
- freeze  out  1  holds the PC and IF/ID.
- bubble  out  1  loads a NOP into ID/EX.
- flush  out  FLUSH_DEPTH  bit i squashes latch i (0 = IF/ID, 1 = ID/EX, ...).
- busy  out  1  state is not RUN, or a redirect is pending.
- stall_cycles, flush_count  out  CNT_W  saturating statistics.

## Operation
- Memory wait: stall_all = ~ihit | (dmem_req & ~dhit). While stall_all=1:
  - state, counter and statistics hold;
  - freeze, bubble and flush are 0;
  - a redirect seen in this cycle sets pending_q.
- Hazard match: a source matches when it is used, equals the destination, and the destination is nonzero. Register x0 never matches.
- Load-use hit (lu): ex_valid & ex_memRead & ex_regWrite & match(ex_rd).
- Non-forwarded RAW hit (raw), only when FORWARD_EN=0: (ex_valid & ex_regWrite & match(ex_rd)) | (mem_regWrite & match(mem_rd)).
- Redirect (redir): ex_valid & (branch_taken | jump), OR'd with pending_q.
- States are RUN and LU_STALL. A 3-bit counter lu_cnt tracks remaining bubbles.
- In RUN with stall_all=0, priority is redirect, then load-use, then RAW:
  - redir: flush = all ones; freeze=0; bubble=0; pending_q clears; flush_count increments.
  - else lu: freeze=1, bubble=1. If LOAD_LATENCY>1, go to LU_STALL with lu_cnt = LOAD_LATENCY-1.
  - else raw: freeze=1, bubble=1. Stay in RUN and re-evaluate next cycle.
  - else all controls are 0.
- In LU_STALL with stall_all=0: freeze=1, bubble=1, and lu_cnt decrements.
  - When lu_cnt==1, return to RUN.
  - A redirect in LU_STALL cannot come from EX (EX holds a bubble). Only pending_q applies: it flushes, aborts the stall and returns to RUN.
- stall_cycles increments on every cycle with freeze | stall_all. Both statistics counters saturate at all ones. perf_clr zeroes them and takes priority over increment.

## Timing
- Reset: while RST=1, every output is 0, including stall_all.
  - On the first edge with RST=1: state=RUN, lu_cnt=0, pending_q=0, counters=0.
  - RST asserted mid-stall or with a redirect pending abandons both. No flush is emitted after reset.
- freeze, bubble and flush are Mealy outputs, combinational from inputs and state in the same cycle. The datapath samples them at the next edge.
- Load-use costs exactly LOAD_LATENCY non-stalled cycles with freeze=1, plus any stall_all cycles interleaved.
- Redirect in cycle t with stall_all=0: flush is high in t only. The PC takes the target at edge t+1.
- Redirect during stall_all: flush is emitted in the first cycle with stall_all=0, for exactly one cycle.
- Redirects arriving while one is pending merge; only one flush is emitted.
- Redirect and lu in the same cycle: flush only, with no bubble and no counter load.

## Test plan
- LOAD_LATENCY=1: load x5 in EX, IF/ID uses rs1=x5 -> freeze=bubble=1 for exactly 1 cycle, then 0; stall_cycles=1.
- LOAD_LATENCY=3, same hazard -> 3 freeze cycles. With stall_all forced for 2 cycles in the middle, 5 total freeze|stall cycles and stall_cycles=5.
- Load with rd=x0, or rs2 matching while fd_rs2_used=0 -> no stall.
- FLUSH_DEPTH=3: jump with ex_valid=1 -> flush=3'b111 for one cycle; flush_count=1. Same jump with ex_valid=0 -> no flush.
- Taken branch while ihit=0 for 4 cycles -> flush=0 during the wait, busy=1, then flush=3'b111 in the first cycle with ihit=1.
- FORWARD_EN=0: mem_rd=x7 with mem_regWrite=1, rs1=x7 -> freeze=1. Then RST pulse mid-LU_STALL -> all outputs 0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / RAW stall and redirect flush control
// for the 5-stage pipeline, with saturating stall and flush statistics.
module hazard_control_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_DEPTH  = 3,
    parameter int FORWARD_EN   = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [REG_W-1:0]       fd_rs1,
    input  logic [REG_W-1:0]       fd_rs2,
    input  logic                   fd_rs1_used,
    input  logic                   fd_rs2_used,
    input  logic                   ex_valid,
    input  logic                   ex_memRead,
    input  logic                   ex_regWrite,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   mem_regWrite,
    input  logic [REG_W-1:0]       mem_rd,
    input  logic                   branch_taken,
    input  logic                   jump,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   dmem_req,
    input  logic                   perf_clr,
    output logic                   stall_all,
    output logic                   freeze,
    output logic                   bubble,
    output logic [FLUSH_DEPTH-1:0] flush,
    output logic                   busy,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       flush_count
);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t                 r_state;
    logic [2:0]             r_lu_cnt;
    logic                   r_pending;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       r_flush_cnt;

    logic                   w_stall;
    logic                   w_m_ex;
    logic                   w_m_mem;
    logic                   w_lu;
    logic                   w_raw;
    logic                   w_ex_redir;
    logic                   w_freeze;
    logic                   w_bubble;
    logic [FLUSH_DEPTH-1:0] w_flush;

    // x0 is hard-wired zero, so a zero destination never creates a hazard
    assign w_m_ex  = (ex_rd != '0) &
                     ((fd_rs1_used & (fd_rs1 == ex_rd)) |
                      (fd_rs2_used & (fd_rs2 == ex_rd)));
    assign w_m_mem = (mem_rd != '0) &
                     ((fd_rs1_used & (fd_rs1 == mem_rd)) |
                      (fd_rs2_used & (fd_rs2 == mem_rd)));

    assign w_lu       = ex_valid & ex_memRead & ex_regWrite & w_m_ex;
    assign w_raw      = (FORWARD_EN == 0) &
                        ((ex_valid & ex_regWrite & w_m_ex) |
                         (mem_regWrite & w_m_mem));
    assign w_ex_redir = ex_valid & (branch_taken | jump);
    assign w_stall    = ~RST & (~ihit | (dmem_req & ~dhit));

    // Mealy pipeline controls; all quiet during reset and memory wait
    always_comb begin
        w_freeze = 1'b0;
        w_bubble = 1'b0;
        w_flush  = '0;
        if (!RST && !w_stall) begin
            case (r_state)
                RUN: begin
                    if (w_ex_redir || r_pending) begin
                        w_flush = '1;
                    end else if (w_lu || w_raw) begin
                        w_freeze = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                LU_STALL: begin
                    if (r_pending) begin
                        w_flush = '1;
                    end else begin
                        w_freeze = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, bubble counter, pending redirect and statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_lu_cnt    <= 3'd0;
            r_pending   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (perf_clr) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if ((w_freeze || w_stall) && !(&r_stall_cnt))
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                if ((|w_flush) && !(&r_flush_cnt))
                    r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_stall) begin
                if (w_ex_redir)
                    r_pending <= 1'b1;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_ex_redir || r_pending) begin
                            r_pending <= 1'b0;
                        end else if (w_lu && (LOAD_LATENCY > 1)) begin
                            r_state  <= LU_STALL;
                            r_lu_cnt <= 3'(LOAD_LATENCY - 1);
                        end
                    end
                    LU_STALL: begin
                        if (r_pending) begin
                            r_pending <= 1'b0;
                            r_state   <= RUN;
                            r_lu_cnt  <= 3'd0;
                        end else begin
                            r_lu_cnt <= r_lu_cnt - 3'd1;
                            if (r_lu_cnt == 3'd1)
                                r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign stall_all    = w_stall;
    assign freeze       = w_freeze;
    assign bubble       = w_bubble;
    assign flush        = w_flush;
    assign busy         = ~RST & ((r_state != RUN) | r_pending |
                                  (w_stall & w_ex_redir));
    assign stall_cycles = RST ? '0 : r_stall_cnt;
    assign flush_count  = RST ? '0 : r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors against two configurations
// (A: LOAD_LATENCY=1, forwarding; B: LOAD_LATENCY=3, no forwarding).
module tb_hazard_control_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] fd_rs1, fd_rs2, ex_rd, mem_rd;
    logic       fd_rs1_used, fd_rs2_used;
    logic       ex_valid, ex_memRead, ex_regWrite, mem_regWrite;
    logic       branch_taken, jump, ihit, dhit, dmem_req, perf_clr;

    logic       a_sa, a_fr, a_bu, a_busy;
    logic [2:0] a_fl;
    logic [15:0] a_sc, a_fc;
    logic       b_sa, b_fr, b_bu, b_busy;
    logic [2:0] b_fl;
    logic [15:0] b_sc, b_fc;

    always #5 CLK = ~CLK;

    hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(1), .FLUSH_DEPTH(3),
                          .FORWARD_EN(1), .CNT_W(16)) u_a (
        .CLK(CLK), .RST(RST), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead),
        .ex_regWrite(ex_regWrite), .ex_rd(ex_rd),
        .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
        .branch_taken(branch_taken), .jump(jump), .ihit(ihit),
        .dhit(dhit), .dmem_req(dmem_req), .perf_clr(perf_clr),
        .stall_all(a_sa), .freeze(a_fr), .bubble(a_bu), .flush(a_fl),
        .busy(a_busy), .stall_cycles(a_sc), .flush_count(a_fc)
    );

    hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(3), .FLUSH_DEPTH(3),
                          .FORWARD_EN(0), .CNT_W(16)) u_b (
        .CLK(CLK), .RST(RST), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead),
        .ex_regWrite(ex_regWrite), .ex_rd(ex_rd),
        .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
        .branch_taken(branch_taken), .jump(jump), .ihit(ihit),
        .dhit(dhit), .dmem_req(dmem_req), .perf_clr(perf_clr),
        .stall_all(b_sa), .freeze(b_fr), .bubble(b_bu), .flush(b_fl),
        .busy(b_busy), .stall_cycles(b_sc), .flush_count(b_fc)
    );

    // ctrl packing: {stall_all, freeze, bubble, busy, flush[2:0]}
    localparam logic [6:0] C0   = 7'b000_0_000;
    localparam logic [6:0] CFB  = 7'b011_0_000;
    localparam logic [6:0] CFBY = 7'b011_1_000;
    localparam logic [6:0] CSA  = 7'b100_0_000;
    localparam logic [6:0] CSAY = 7'b100_1_000;
    localparam logic [6:0] CFL  = 7'b000_0_111;
    localparam logic [6:0] CFLY = 7'b000_1_111;

    typedef struct {
        string       nm;
        logic [6:0]  a_ctrl;
        logic [15:0] a_sc;
        logic [15:0] a_fc;
        logic [6:0]  b_ctrl;
        logic [15:0] b_sc;
        logic [15:0] b_fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   drv_done = 1'b0;

    task automatic chk(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "A_ctrl", {9'd0, a_sa, a_fr, a_bu, a_busy, a_fl},
                {9'd0, e.a_ctrl});
            chk(e.nm, "A_stall_cycles", a_sc, e.a_sc);
            chk(e.nm, "A_flush_count", a_fc, e.a_fc);
            chk(e.nm, "B_ctrl", {9'd0, b_sa, b_fr, b_bu, b_busy, b_fl},
                {9'd0, e.b_ctrl});
            chk(e.nm, "B_stall_cycles", b_sc, e.b_sc);
            chk(e.nm, "B_flush_count", b_fc, e.b_fc);
        end
    end

    task automatic idle();
        fd_rs1 = 5'd0; fd_rs2 = 5'd0;
        fd_rs1_used = 1'b0; fd_rs2_used = 1'b0;
        ex_valid = 1'b0; ex_memRead = 1'b0; ex_regWrite = 1'b0;
        ex_rd = 5'd0; mem_regWrite = 1'b0; mem_rd = 5'd0;
        branch_taken = 1'b0; jump = 1'b0;
        ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_valid = 1'b1; ex_memRead = 1'b1; ex_regWrite = 1'b1;
        ex_rd = rd;
    endtask

    task automatic use_rs1(input logic [4:0] r);
        fd_rs1 = r; fd_rs1_used = 1'b1;
    endtask

    task automatic cyc(input string nm,
                       input logic [6:0] ac, input int asc, input int afc,
                       input logic [6:0] bc, input int bsc, input int bfc);
        exp_t e;
        e.nm = nm;
        e.a_ctrl = ac; e.a_sc = 16'(asc); e.a_fc = 16'(afc);
        e.b_ctrl = bc; e.b_sc = 16'(bsc); e.b_fc = 16'(bfc);
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        ihit = 1'b0;
        cyc("rst_ihit0", C0, 0, 0, C0, 0, 0);
        idle();
        cyc("rst", C0, 0, 0, C0, 0, 0);
        RST = 1'b0;

        idle(); load_in_ex(5'd5); use_rs1(5'd5);
        cyc("lu1", CFB, 0, 0, CFB, 0, 0);
        idle(); use_rs1(5'd5); mem_regWrite = 1'b1; mem_rd = 5'd5;
        cyc("lu2", C0, 1, 0, CFBY, 1, 0);
        cyc("lu3", C0, 1, 0, CFBY, 2, 0);
        idle();
        cyc("lu_done", C0, 1, 0, C0, 3, 0);
        perf_clr = 1'b1;
        cyc("perf_clr", C0, 1, 0, C0, 3, 0);

        idle(); load_in_ex(5'd5); use_rs1(5'd5);
        cyc("lus1", CFB, 0, 0, CFB, 0, 0);
        idle(); use_rs1(5'd5); ihit = 1'b0;
        cyc("lus_wait1", CSA, 1, 0, CSAY, 1, 0);
        cyc("lus_wait2", CSA, 2, 0, CSAY, 2, 0);
        ihit = 1'b1;
        cyc("lus2", C0, 3, 0, CFBY, 3, 0);
        cyc("lus3", C0, 3, 0, CFBY, 4, 0);
        idle();
        cyc("lus_done", C0, 3, 0, C0, 5, 0);

        idle(); load_in_ex(5'd0); use_rs1(5'd0);
        cyc("rd_x0", C0, 3, 0, C0, 5, 0);
        idle(); load_in_ex(5'd6); use_rs1(5'd1);
        fd_rs2 = 5'd6; fd_rs2_used = 1'b0;
        cyc("rs2_unused", C0, 3, 0, C0, 5, 0);

        idle(); ex_valid = 1'b1; jump = 1'b1;
        cyc("jump", CFL, 3, 0, CFL, 5, 0);
        ex_valid = 1'b0;
        cyc("jump_invalid", C0, 3, 1, C0, 5, 1);
        idle();
        cyc("jump_after", C0, 3, 1, C0, 5, 1);

        idle(); ex_valid = 1'b1; branch_taken = 1'b1; ihit = 1'b0;
        cyc("br_wait1", CSAY, 3, 1, CSAY, 5, 1);
        cyc("br_wait2", CSAY, 4, 1, CSAY, 6, 1);
        cyc("br_wait3", CSAY, 5, 1, CSAY, 7, 1);
        cyc("br_wait4", CSAY, 6, 1, CSAY, 8, 1);
        ihit = 1'b1;
        cyc("br_flush", CFLY, 7, 1, CFLY, 9, 1);
        idle();
        cyc("br_after", C0, 7, 2, C0, 9, 2);

        idle(); mem_regWrite = 1'b1; mem_rd = 5'd7; use_rs1(5'd7);
        cyc("raw_mem", C0, 7, 2, CFB, 9, 2);
        idle(); load_in_ex(5'd5); use_rs1(5'd5);
        cyc("lu_pre_rst", CFB, 7, 2, CFB, 10, 2);
        idle(); use_rs1(5'd5);
        cyc("lu_stall_pre_rst", C0, 8, 2, CFBY, 11, 2);
        RST = 1'b1; ihit = 1'b0;
        cyc("rst_mid_stall", C0, 0, 0, C0, 0, 0);
        RST = 1'b0; idle();
        cyc("post_rst", C0, 0, 0, C0, 0, 0);

        idle(); ex_valid = 1'b1; branch_taken = 1'b1; ihit = 1'b0;
        cyc("pend_before_rst", CSAY, 0, 0, CSAY, 0, 0);
        RST = 1'b1;
        cyc("rst_pending", C0, 0, 0, C0, 0, 0);
        RST = 1'b0; idle();
        cyc("no_flush_after_rst", C0, 0, 0, C0, 0, 0);

        idle(); load_in_ex(5'd5); use_rs1(5'd5); jump = 1'b1;
        cyc("redir_and_lu", CFL, 0, 0, CFL, 0, 0);
        idle();
        cyc("redir_and_lu_after", C0, 0, 1, C0, 0, 1);
        drv_done = 1'b1;
    end

    initial begin
        wait (drv_done);
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge CLK);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete, expected finish");
        $fatal(1);
    end

endmodule
